spgd_perturb_sequencer: RTL

- Sequences one SPGD iteration over N_CH actuator channels:
  - apply a +delta perturbation and sample the metric J+;
  - apply a -delta perturbation and sample J-;
  - update every control word by the scaled metric difference.
- All add/sub results are saturated to the unsigned actuator range [0, 2^(W-1)-1], using MSB-as-overflow semantics.
- One shared saturating adder is time-multiplexed across channels.
- Sits between the metric detector (input) and the DAC write port (output).

---
 rtl/spgd_perturb_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/spgd_perturb_sequencer.sv
// SPGD perturbation sequencer: +/- dither, metric capture, gradient update.
// Optional SPGD_SAT_COUNT_EN adds a saturating clamp counter port.
module spgd_perturb_sequencer #(
  parameter int          W          = 14,
  parameter int          N_CH       = 4,
  parameter int          MW         = 16,
  parameter int          SETTLE     = 8,
  parameter int          GAIN_SHIFT = 4,
  parameter int          DELTA      = 64,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [MW-1:0]                          metric,
  input  logic                                   metric_valid,
  output logic [W-1:0]                           dac_data,
  output logic [$clog2(N_CH>1 ? N_CH : 2)-1:0]   dac_ch,
  output logic                                   dac_wr,
  output logic                                   busy,
  output logic                                   done,
  output logic signed [MW:0]                     dJ_out
`ifdef SPGD_SAT_COUNT_EN
  ,output logic [15:0]                           sat_count
`endif
);

  localparam int CHW  = $clog2(N_CH > 1 ? N_CH : 2);
  localparam int CNTW = $clog2(SETTLE + 1);
  localparam int CW   = ((W > MW + 1) ? W : MW + 1) + 1;
  localparam logic signed [CW-1:0] MAXV = CW'((1 << (W - 1)) - 1);
  localparam logic [W-1:0] MID = W'(1 << (W - 2));

  typedef enum logic [3:0] {
    IDLE, PLUS, SET_P, SAMP_P, MINUS, SET_M, SAMP_M, UPDATE
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]      u [N_CH];
  logic [N_CH-1:0]   sgn;
  logic [15:0]       lfsr;
  logic [CHW-1:0]    idx;
  logic [CNTW-1:0]   cnt;
  logic [MW-1:0]     jp_q;
  logic signed [MW:0] step;

  logic last, settle_last, sub;
  logic signed [CW-1:0] opa, opb, sum;
  logic clamp_lo, clamp_hi;
  logic [W-1:0] sat_res;

  assign last        = (idx == CHW'(N_CH - 1));
  assign settle_last = (cnt == CNTW'(SETTLE - 1));
  assign step        = dJ_out >>> GAIN_SHIFT;

  // Shared saturating adder, operand B is DELTA or the scaled gradient
  always_comb begin
    opa = {{(CW-W){1'b0}}, u[idx]};
    opb = CW'(DELTA);
    if (state_q == UPDATE)
      opb = {{(CW-MW-1){step[MW]}}, step};
    sum      = sub ? (opa - opb) : (opa + opb);
    clamp_lo = sum[CW-1];
    clamp_hi = !sum[CW-1] && (sum > MAXV);
    sat_res  = clamp_lo ? '0 :
               clamp_hi ? MAXV[W-1:0] : sum[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    dac_wr  = 1'b0;
    done    = 1'b0;
    sub     = 1'b0;
    busy    = (state_q != IDLE);
    unique case (state_q)
      IDLE:   if (start) state_d = PLUS;
      PLUS: begin
        dac_wr = 1'b1;
        sub    = sgn[idx];
        if (last) state_d = SET_P;
      end
      SET_P:  if (settle_last) state_d = SAMP_P;
      SAMP_P: if (metric_valid) state_d = MINUS;
      MINUS: begin
        dac_wr = 1'b1;
        sub    = !sgn[idx];
        if (last) state_d = SET_M;
      end
      SET_M:  if (settle_last) state_d = SAMP_M;
      SAMP_M: if (metric_valid) state_d = UPDATE;
      UPDATE: begin
        dac_wr = 1'b1;
        sub    = sgn[idx];
        if (last) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    dac_data = dac_wr ? sat_res : '0;
    dac_ch   = dac_wr ? idx : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr    <= SEED;
      sgn     <= '0;
      idx     <= '0;
      cnt     <= '0;
      jp_q    <= '0;
      dJ_out  <= '0;
      for (int i = 0; i < N_CH; i++) u[i] <= MID;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (start) begin
          sgn  <= lfsr[N_CH-1:0];
          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
          idx  <= '0;
        end
        PLUS, MINUS: idx <= last ? '0 : idx + 1'b1;
        UPDATE: begin
          u[idx] <= sat_res;
          idx    <= last ? '0 : idx + 1'b1;
        end
        SET_P, SET_M: cnt <= settle_last ? '0 : cnt + 1'b1;
        SAMP_P: if (metric_valid) jp_q <= metric;
        SAMP_M: if (metric_valid)
          dJ_out <= $signed({1'b0, jp_q}) - $signed({1'b0, metric});
        default: ;
      endcase
    end
  end

`ifdef SPGD_SAT_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      sat_count <= '0;
    else if (state_q == IDLE && start)
      sat_count <= '0;
    else if (dac_wr && (clamp_lo || clamp_hi) && sat_count != 16'hFFFF)
      sat_count <= sat_count + 16'd1;
  end
`endif

endmodule
